// File: rtl/random_onehot_picker_pkg.sv
// Shared constants and helpers for the random one-hot picker: LFSR seed, tap set
// and the ceiling-log used to size index buses.
package random_onehot_picker_pkg;

  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  localparam int          LFSR_NTAPS = 4;
  // Taps of x^32+x^22+x^2+x+1, expressed as bit positions of the shift register.
  localparam int          LFSR_TAPS [LFSR_NTAPS] = '{31, 21, 1, 0};

  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int p = 1; p < n; p = p * 2) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic fb;
    fb = 1'b0;
    for (int t = 0; t < LFSR_NTAPS; t++) begin
      fb = fb ^ s[LFSR_TAPS[t]];
    end
    return {s[30:0], fb};
  endfunction

endpackage

// File: rtl/random_onehot_picker_onehot_encoder.sv
// One-hot to binary index encoder with an all-zero flag; purely combinational.
// An all-zero input yields index 0.
module onehot_encoder
  import random_onehot_picker_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]        onehot_i,
  output logic [log2c(N)-1:0] idx_o,
  output logic                zero_o
);

  localparam int IW = log2c(N);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot_i[i]) begin
        idx_o = idx_o | IW'(i);
      end
    end
  end

  assign zero_o = ~|onehot_i;

endmodule

// File: rtl/random_onehot_picker.sv
// Grants one set request bit, searching upward (with wrap) from an LFSR-derived offset.
// Grant is combinational from req_i and the registered LFSR state; only the LFSR is stateful.
module random_onehot_picker
  import random_onehot_picker_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic [N-1:0]        req_i,
  output logic [31:0]         rand_o,
  output logic [N-1:0]        grant_o,
  output logic [log2c(N)-1:0] grant_idx_o,
  output logic                none_o
);

  localparam int          IW    = log2c(N);
  localparam logic [IW:0] N_EXT = (IW + 1)'(N);

  logic [31:0]   rand_q;
  logic [31:0]   rand_d;
  logic [IW-1:0] k_raw;
  logic [IW-1:0] k;
  logic [N-1:0]  rot_req;
  logic [N-1:0]  pick;

  always_comb begin
    rand_d = rand_q;
    if (en_i) begin
      rand_d = lfsr_next(rand_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rand_q <= LFSR_SEED;
    end else begin
      rand_q <= rand_d;
    end
  end

  assign rand_o = rand_q;

  // Raw offset can exceed N-1 only when N is not a power of two; one subtraction suffices.
  assign k_raw = rand_q[IW-1:0];
  assign k     = ({1'b0, k_raw} >= N_EXT) ? (k_raw - IW'(N)) : k_raw;

  always_comb begin
    rot_req = N'({req_i, req_i} >> k);
    // Isolate lowest set bit: x & -x.
    pick    = rot_req & (~rot_req + {{(N-1){1'b0}}, 1'b1});
    grant_o = N'(({pick, pick} << k) >> N);
  end

  onehot_encoder #(
    .N(N)
  ) u_enc (
    .onehot_i(grant_o),
    .idx_o   (grant_idx_o),
    .zero_o  (none_o)
  );

endmodule

// File: tb/tb_random_onehot_picker.sv
module tb_random_onehot_picker;

  logic        clk;
  logic        reset;
  logic        en;
  logic [7:0]  req8;
  logic [4:0]  req5;
  logic [31:0] rand8, rand5;
  logic [7:0]  grant8;
  logic [4:0]  grant5;
  logic [2:0]  idx8, idx5;
  logic        none8, none5;

  int checks = 0;
  int errors = 0;

  random_onehot_picker #(.N(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .en_i(en), .req_i(req8),
    .rand_o(rand8), .grant_o(grant8), .grant_idx_o(idx8), .none_o(none8)
  );

  random_onehot_picker #(.N(5)) dut5 (
    .clk_i(clk), .reset_i(reset), .en_i(en), .req_i(req5),
    .rand_o(rand5), .grant_o(grant5), .grant_idx_o(idx5), .none_o(none5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Reference search for N=5: walk upward from k, wrapping at 4.
  task automatic ref_pick5(input logic [4:0] r, input logic [31:0] s,
                           output logic [4:0] g, output logic [2:0] gi, output logic nz);
    int kk;
    int pos;
    kk = int'(s[2:0]);
    if (kk >= 5) kk = kk - 5;
    g  = '0;
    gi = '0;
    nz = 1'b1;
    for (int j = 0; j < 5; j++) begin
      pos = (kk + j) % 5;
      if (nz && r[pos]) begin
        g[pos] = 1'b1;
        gi     = 3'(pos);
        nz     = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] model_r;
    logic [4:0]  eg;
    logic [2:0]  ei;
    logic        en_;

    reset = 1'b0;
    en    = 1'b1;
    req8  = 8'b1000_0001;
    req5  = 5'b00000;

    // Reset held for two edges, with en asserted.
    tick();
    check("rst_rand_c1", rand8, 32'h1);
    tick();
    check("rst_rand_c2", rand8, 32'h1);
    check("rst_rand5", rand5, 32'h1);
    #1;
    check("k1_grant", 32'(grant8), 32'h80);
    check("k1_idx", 32'(idx8), 32'd7);
    check("k1_none", 32'(none8), 32'd0);
    check("n5_none_zero_req", 32'(none5), 32'd1);

    reset = 1'b1;
    tick();
    check("step_3", rand8, 32'h3);
    req8 = 8'b0000_0101;
    #1;
    check("wrap_grant", 32'(grant8), 32'h01);
    check("wrap_idx", 32'(idx8), 32'd0);

    tick();
    check("step_6", rand8, 32'h6);
    req8 = 8'hFF;
    #1;
    check("all_grant", 32'(grant8), 32'h40);
    check("all_idx", 32'(idx8), 32'd6);
    check("all_none", 32'(none8), 32'd0);
    req8 = 8'h00;
    #1;
    check("zero_grant", 32'(grant8), 32'h00);
    check("zero_idx", 32'(idx8), 32'd0);
    check("zero_none", 32'(none8), 32'd1);

    tick();
    check("step_D", rand8, 32'hD);
    // N=8: k=5; N=5: raw 5 folds to k=0.
    req8 = 8'b0001_0000;
    req5 = 5'b10100;
    #1;
    check("k5_grant8", 32'(grant8), 32'h10);
    check("k5_idx8", 32'(idx8), 32'd4);
    check("fold_grant5", 32'(grant5), 32'h04);
    check("fold_idx5", 32'(idx5), 32'd2);

    tick();
    check("step_1B", rand8, 32'h1B);
    req8 = 8'b0000_1000;
    req5 = 5'b00011;
    #1;
    check("k3_grant8", 32'(grant8), 32'h08);
    check("k3_idx8", 32'(idx8), 32'd3);
    check("n5_grant", 32'(grant5), 32'h01);
    check("n5_idx", 32'(idx5), 32'd0);
    check("n5_none", 32'(none5), 32'd0);

    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_rand", rand8, 32'h1B);
    end

    en    = 1'b1;
    reset = 1'b0;
    req8  = 8'b1000_0001;
    tick();
    check("midrst_rand", rand8, 32'h1);
    check("midrst_rand5", rand5, 32'h1);
    #1;
    check("midrst_grant", 32'(grant8), 32'h80);
    check("midrst_idx", 32'(idx8), 32'd7);

    reset   = 1'b1;
    model_r = 32'h1;
    for (int c = 0; c < 1000; c++) begin
      req5 = 5'($urandom_range(0, 31));
      #1;
      ref_pick5(req5, model_r, eg, ei, en_);
      check("sweep_rand", rand5, model_r);
      check("sweep_grant", 32'(grant5), 32'(eg));
      check("sweep_idx", 32'(idx5), 32'(ei));
      check("sweep_none", 32'(none5), 32'(en_));
      tick();
      model_r = ref_step(model_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
